// File: rtl/recv_pkg.sv
// recv_pkg: shared frame geometry, parity sense and FSM encoding for the UART receiver
package recv_pkg;
    localparam int DATA_BITS = 128;
    localparam int OVERSAMPLE = 16;
    localparam logic PARITY_ODD = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/rx_sync.sv
// rx_sync: two-flop synchronizer for the asynchronous serial line, idles high
module rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    // shift the raw line through two flops; reset to the idle (mark) level
    always_ff @(posedge clock) sync_q <= reset ? 2'b11 : {sync_q[0], d_i};
    assign q_o = sync_q[1];
endmodule

// File: rtl/recv.sv
// recv: oversampling UART receiver with odd parity, frame checks and a done level for the sender's ack slot
module recv #(
    parameter int DATA_BITS  = recv_pkg::DATA_BITS,
    parameter int OVERSAMPLE = recv_pkg::OVERSAMPLE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] outval,
    output logic                 rx_done,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err
);
    import recv_pkg::*;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;
    logic                 rx_s;
    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, out_q, out_d;
    logic                 par_q, par_d, pok_q, pok_d;
    logic                 done_q, done_d, valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                 samp;

    rx_sync u_sync (.clock(clock), .reset(reset), .d_i(UART_RX), .q_o(rx_s));

    assign samp = (tick_q == TW'(OVERSAMPLE - 1));

    // next-state and datapath: start is confirmed at mid-bit, later bits sampled once per bit period
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pok_d   = pok_q;
        out_d   = out_q;
        done_d  = done_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (tick_q == TW'(OVERSAMPLE / 2 - 1)) begin
                    tick_d  = '0;
                    state_d = rx_s ? IDLE : DATA;
                    if (!rx_s) begin
                        bit_d  = '0;
                        par_d  = 1'b0;
                        done_d = 1'b0;
                        perr_d = 1'b0;
                        ferr_d = 1'b0;
                    end
                end
            end
            DATA: begin
                if (samp) begin
                    tick_d  = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ rx_s;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BW'(DATA_BITS - 1)) state_d = PARITY;
                end
            end
            PARITY: begin
                if (samp) begin
                    tick_d  = '0;
                    pok_d   = ((par_q ^ rx_s) == PARITY_ODD);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (samp) begin
                    tick_d  = '0;
                    state_d = IDLE;
                    if (!rx_s) ferr_d = 1'b1;
                    else if (!pok_q) perr_d = 1'b1;
                    else begin
                        out_d   = shift_q;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; reset overrides everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            pok_q   <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            pok_q   <= pok_d;
            out_q   <= out_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign outval     = out_q;
    assign rx_done    = done_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
endmodule

// File: tb/tb_recv.sv
// tb_recv: drives serial frames into recv and checks it against a frame-level reference model
module tb_recv;
    import recv_pkg::*;
    localparam int DB = 128;
    localparam int OS = 16;
    localparam logic [DB-1:0] K = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          UART_RX = 1'b1;
    logic [DB-1:0] outval;
    logic          rx_done, rx_valid, parity_err, frame_err;

    int n_chk = 0;
    int n_fail = 0;
    int valid_cnt = 0;
    int exp_valid_cnt = 0;
    bit chk_en = 1'b0;
    logic [DB-1:0] exp_out = '0;
    logic exp_done = 1'b0, exp_perr = 1'b0, exp_ferr = 1'b0;

    recv #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clock(clock), .reset(reset), .UART_RX(UART_RX), .outval(outval),
        .rx_done(rx_done), .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // outputs only move at start acceptance and stop sampling; elsewhere they must match the model
    always @(posedge clock) begin
        #1;
        if (rx_valid === 1'b1) valid_cnt++;
        if (chk_en) begin
            check("outval", outval, exp_out);
            check("rx_done", DB'(rx_done), DB'(exp_done));
            check("parity_err", DB'(parity_err), DB'(exp_perr));
            check("frame_err", DB'(frame_err), DB'(exp_ferr));
            check("rx_valid_quiet", DB'(rx_valid), '0);
        end
    end

    task automatic start_bit();
        @(negedge clock);
        chk_en = 1'b0;
        UART_RX = 1'b0;
        repeat (OS) @(posedge clock);
        exp_done = 1'b0;
        exp_perr = 1'b0;
        exp_ferr = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clock);
        UART_RX = b;
        repeat (OS) @(posedge clock);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic par_flip, input logic stop, output logic acked);
        logic good;
        int rise;
        good = stop && !par_flip;
        start_bit();
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        send_bit(~(^d) ^ par_flip);
        @(negedge clock);
        chk_en = 1'b0;
        UART_RX = stop;
        rise = 0;
        for (int i = 1; i <= OS; i++) begin
            @(posedge clock);
            #1;
            if (rise == 0 && rx_done === 1'b1) rise = i;
        end
        acked = rx_done;
        @(negedge clock);
        UART_RX = 1'b1;
        if (good) begin
            exp_out = d;
            exp_done = 1'b1;
            exp_valid_cnt++;
        end else if (!stop) exp_ferr = 1'b1;
        else exp_perr = 1'b1;
        check("ack_slot", DB'(acked), DB'(good));
        check("done_rise_window", DB'(good ? (rise >= 1 && rise <= 12) : (rise == 0)), DB'(1));
        check("valid_count", DB'(valid_cnt), DB'(exp_valid_cnt));
        chk_en = 1'b1;
    endtask

    task automatic tx_send(input logic [DB-1:0] d, input int corrupt, output int tries);
        logic ack;
        tries = 0;
        ack = 1'b0;
        while (!ack && tries < 3) begin
            send_frame(d, tries < corrupt, 1'b1, ack);
            tries++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [DB-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic ack;
        int tries;
        logic [DB-1:0] a;
        repeat (3) @(negedge clock);
        check("reset_outval", outval, '0);
        check("reset_flags", DB'({rx_done, rx_valid, parity_err, frame_err}), '0);
        reset = 1'b0;
        chk_en = 1'b1;
        idle(4);

        send_frame(K, 1'b0, 1'b1, ack);
        check("lit_outval_K", outval, K);

        send_frame('0, 1'b1, 1'b1, ack);
        check("lit_zero_bad_parity_err", DB'(parity_err), DB'(1));
        check("lit_zero_bad_done", DB'(rx_done), DB'(0));
        check("lit_zero_bad_hold", outval, K);
        send_frame('0, 1'b0, 1'b1, ack);
        check("lit_zero_good", outval, '0);
        check("lit_zero_good_perr", DB'(parity_err), DB'(0));

        send_frame({DB{1'b1}}, 1'b0, 1'b0, ack);
        check("lit_stop0_ferr", DB'(frame_err), DB'(1));
        check("lit_stop0_done", DB'(rx_done), DB'(0));
        check("lit_stop0_hold", outval, '0);
        idle(24);

        @(negedge clock);
        UART_RX = 1'b0;
        idle(5);
        UART_RX = 1'b1;
        idle(20);
        check("glitch_state", DB'(dut.state_q), DB'(IDLE));
        check("glitch_flags", DB'(frame_err), DB'(1));

        start_bit();
        for (int i = 0; i < 60; i++) send_bit(1'b1);
        @(negedge clock);
        chk_en = 1'b0;
        reset = 1'b1;
        UART_RX = 1'b1;
        @(negedge clock);
        check("midreset_outval", outval, '0);
        check("midreset_flags", DB'({rx_done, rx_valid, parity_err, frame_err}), '0);
        check("midreset_state", DB'(dut.state_q), DB'(IDLE));
        reset = 1'b0;
        exp_out = '0;
        exp_done = 1'b0;
        exp_perr = 1'b0;
        exp_ferr = 1'b0;
        chk_en = 1'b1;
        idle(3);
        send_frame(128'h1, 1'b0, 1'b1, ack);
        check("lit_after_reset", outval, 128'h1);

        tx_send(rand_word(), 0, tries);
        check("loop_tries_a", DB'(tries), DB'(1));
        tx_send(rand_word(), 0, tries);
        check("loop_tries_b", DB'(tries), DB'(1));
        a = rand_word();
        tx_send(a, 1, tries);
        check("loop_tries_resend", DB'(tries), DB'(2));
        check("loop_resend_data", outval, a);

        for (int n = 0; n < 6; n++) begin
            logic flip, stop;
            flip = ($urandom_range(3) == 0);
            stop = ($urandom_range(3) != 0);
            send_frame(rand_word(), flip, stop, ack);
            idle(stop ? $urandom_range(0, 8) : 24);
        end

        idle(10);
        check("final_valid_count", DB'(valid_cnt), DB'(exp_valid_cnt));
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
